// File: rtl/wb_arbiter2m.sv
// Two-master Wishbone classic arbiter in front of wb_switch: round-robin grant, optional
// per-tenure ack limit (MAX_BURST) and, with WB_ARB_TIMEOUT_EN defined, a stalled-strobe bus error.
module wb_arbiter2m #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [1:0]  m_cyc,
  input  logic [1:0]  m_stb,
  input  logic [1:0]  m_we,
  input  logic [7:0]  m_sel,
  input  logic [63:0] m_adr,
  input  logic [63:0] m_dat_o,
  output logic [31:0] m_dat_i,
  output logic [1:0]  m_ack,
  output logic [1:0]  m_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  output logic [1:0]  grant
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;
  localparam logic [7:0] MB   = 8'(MAX_BURST);

  logic [1:0] state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] ack_cnt;
  logic       active, own, oth, hold, change, tmo_hit;

  assign active  = (state != IDLE);
  assign own     = (state == GNT1);
  assign oth     = ~own;
  assign grant   = state;
  assign m_dat_i = s_dat_i;
  assign hold    = (MAX_BURST != 0) && active && (ack_cnt == MB) && m_cyc[oth];
  assign change  = (state_nxt != state);

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_adr   = '0;
    s_dat_o = '0;
    m_ack   = '0;
    m_err   = '0;
    if (active) begin
      s_cyc   = m_cyc[own];
      s_stb   = m_stb[own] & ~hold & ~tmo_hit;
      s_we    = m_we[own];
      s_sel   = own ? m_sel[7:4]    : m_sel[3:0];
      s_adr   = own ? m_adr[63:32]  : m_adr[31:0];
      s_dat_o = own ? m_dat_o[63:32] : m_dat_o[31:0];
      m_ack[own] = s_ack & s_stb;
      m_err[own] = tmo_hit;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    if (!active) begin
      if (m_cyc[0] && m_cyc[1]) state_nxt = last ? GNT0 : GNT1;
      else if (m_cyc[0])        state_nxt = GNT0;
      else if (m_cyc[1])        state_nxt = GNT1;
    end else if (!m_cyc[own]) begin
      // a drop by the owner together with a raise by the other hands over directly
      state_nxt = m_cyc[oth] ? (oth ? GNT1 : GNT0) : IDLE;
      last_nxt  = own;
    end else if (hold) begin
      state_nxt = oth ? GNT1 : GNT0;
      last_nxt  = own;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      last    <= 1'b1;
      ack_cnt <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      if (change)
        ack_cnt <= '0;
      else if (s_stb && s_ack && ack_cnt != MB)
        ack_cnt <= ack_cnt + 8'd1;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TW  = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  logic [TW-1:0] tmo_cnt;

  // hit is judged on the raw master strobe so the forced-low s_stb cannot feed back into it
  assign tmo_hit = active && m_cyc[own] && m_stb[own] && (tmo_cnt == TMO);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      tmo_cnt <= '0;
    else if (change)
      tmo_cnt <= '0;
    else if (s_cyc && s_stb && !s_ack)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2m.sv
// Randomized bench for wb_arbiter2m against a cycle-level ownership/counter model.
// Expectations follow WB_ARB_TIMEOUT_EN the same way the design build does.
module tb_wb_arbiter2m;

  localparam int unsigned MB = 4;
  localparam int unsigned TO = 16;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [7:0]  m_sel;
  logic [63:0] m_adr, m_dat_o;
  logic [31:0] m_dat_i;
  logic [1:0]  m_ack, m_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic        s_ack;
  logic [1:0]  grant;

  wb_arbiter2m #(.MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_b(rst_b),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_adr(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: owner -1 = nobody, else master index; last = previous owner.
  int owner = -1;
  int last  = 1;
  int acnt  = 0;
  int tcnt  = 0;
  bit e_stb, e_hold, e_hit;

  task automatic model_reset();
    owner = -1;
    last  = 1;
    acnt  = 0;
    tcnt  = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [1:0]  e_grant, e_ack, e_err;
    bit          e_cyc, e_we;
    int          y;
    e_adr = '0; e_dat = '0; e_sel = '0; e_grant = '0; e_ack = '0; e_err = '0;
    e_cyc = 0; e_we = 0; e_stb = 0; e_hold = 0; e_hit = 0;
    if (owner >= 0) begin
      y       = 1 - owner;
      e_grant = (owner == 0) ? 2'b01 : 2'b10;
      e_hold  = (MB != 0) && (acnt == MB) && m_cyc[y];
      e_hit   = TMO_EN && m_cyc[owner] && m_stb[owner] && (tcnt == TO);
      e_cyc   = m_cyc[owner];
      e_stb   = m_stb[owner] && !e_hold && !e_hit;
      e_we    = m_we[owner];
      e_sel   = m_sel[owner*4 +: 4];
      e_adr   = m_adr[owner*32 +: 32];
      e_dat   = m_dat_o[owner*32 +: 32];
      e_ack[owner] = e_stb && s_ack;
      e_err[owner] = e_hit;
    end
    check("grant", grant, e_grant);
    check("s_cyc", s_cyc, e_cyc);
    check("s_stb", s_stb, e_stb);
    check("s_we", s_we, e_we);
    check("s_sel", s_sel, e_sel);
    check("s_adr", s_adr, e_adr);
    check("s_dat_o", s_dat_o, e_dat);
    check("m_ack", m_ack, e_ack);
    check("m_err", m_err, e_err);
    check("m_dat_i", m_dat_i, s_dat_i);
  endtask

  task automatic model_step();
    int nxt;
    nxt = owner;
    if (owner < 0) begin
      if (m_cyc == 2'b11) nxt = (last == 1) ? 0 : 1;
      else if (m_cyc[0])  nxt = 0;
      else if (m_cyc[1])  nxt = 1;
    end else if (!m_cyc[owner]) begin
      nxt  = m_cyc[1 - owner] ? 1 - owner : -1;
      last = owner;
    end else if (e_hold) begin
      nxt  = 1 - owner;
      last = owner;
    end
    if (nxt != owner) begin
      acnt = 0;
      tcnt = 0;
    end else begin
      if (e_stb && s_ack && acnt < MB) acnt++;
      if (TMO_EN && owner >= 0 && m_cyc[owner] && e_stb && !s_ack) tcnt++;
      else tcnt = 0;
    end
    owner = nxt;
  endtask

  task automatic do_cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst_b) model_step();
    else model_reset();
    #1;
  endtask

  task automatic rand_data();
    m_we    = 2'($urandom);
    m_sel   = 8'($urandom);
    m_adr   = {$urandom, $urandom};
    m_dat_o = {$urandom, $urandom};
    s_dat_i = $urandom;
  endtask

  task automatic rand_masters();
    for (int n = 0; n < 2; n++) begin
      if (!m_cyc[n]) begin
        m_cyc[n] = ($urandom_range(2) == 0);
        m_stb[n] = m_cyc[n];
      end else if ($urandom_range(9) == 0) begin
        m_cyc[n] = 1'b0;
        m_stb[n] = 1'b0;
      end else begin
        m_stb[n] = ($urandom_range(4) != 0);
      end
    end
  endtask

  initial begin
    rst_b = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
    m_adr = '0; m_dat_o = '0; s_dat_i = '0; s_ack = 1'b0;
    #3;
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_m_ack", m_ack, 2'b00);
    check("rst_m_err", m_err, 2'b00);
    @(posedge clk);
    #1 rst_b = 1'b1;

    repeat (400) begin
      rand_masters();
      rand_data();
      s_ack = ($urandom_range(3) != 0);
      do_cycle();
    end

    // slave silent: exercises the timeout (or a permanent stall without it)
    repeat (50) begin
      m_cyc = 2'b01;
      m_stb = 2'b01;
      rand_data();
      s_ack = 1'b0;
      do_cycle();
    end

    repeat (6) begin
      m_cyc = 2'b10;
      m_stb = 2'b10;
      rand_data();
      s_ack = $urandom_range(1);
      do_cycle();
    end
    check("pre_rst_grant", grant, 2'b10);

    // asynchronous reset in the middle of a master-1 tenure
    #2 rst_b = 1'b0;
    #1;
    check("async_grant", grant, 2'b00);
    check("async_s_cyc", s_cyc, 1'b0);
    check("async_s_stb", s_stb, 1'b0);
    model_reset();
    m_cyc = 2'b11;
    m_stb = 2'b11;
    @(posedge clk);
    #1 rst_b = 1'b1;
    do_cycle();
    check("first_grant", grant, 2'b01);

    repeat (400) begin
      rand_masters();
      rand_data();
      s_ack = ($urandom_range(3) != 0);
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
